// File: rtl/axi_lite_master.sv
// AXI4-Lite initiator: converts single register commands into AXI4-Lite write or read
// transactions, one outstanding at a time, with a sticky watchdog for stalled responders.
`timescale 1ns/1ps

module axi_lite_master #(
  parameter int C_M_AXI_ADDR_WIDTH = 4,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES     = 1024
) (
  input  logic                            m_axi_aclk,
  input  logic                            m_axi_aresetn,

  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic                            cmd_write,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,

  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic                            rsp_write,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]                      rsp_resp,
  output logic                            timeout,

  output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [2:0]                      m_axi_awprot,
  output logic                            m_axi_awvalid,
  input  logic                            m_axi_awready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                            m_axi_wvalid,
  input  logic                            m_axi_wready,
  input  logic [1:0]                      m_axi_bresp,
  input  logic                            m_axi_bvalid,
  output logic                            m_axi_bready,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [2:0]                      m_axi_arprot,
  output logic                            m_axi_arvalid,
  input  logic                            m_axi_arready,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]                      m_axi_rresp,
  input  logic                            m_axi_rvalid,
  output logic                            m_axi_rready
);

  localparam int STRB_W = C_M_AXI_DATA_WIDTH / 8;
  localparam int WD_W   = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_REQ,
    RD_DATA,
    RSP
  } state_t;

  state_t          state;
  logic [WD_W-1:0] wd_cnt;
  logic            aw_fire;
  logic            w_fire;
  logic            ar_fire;
  logic            in_wait;

  assign m_axi_awprot = 3'b000;
  assign m_axi_arprot = 3'b000;

  assign aw_fire = m_axi_awvalid && m_axi_awready;
  assign w_fire  = m_axi_wvalid && m_axi_wready;
  assign ar_fire = m_axi_arvalid && m_axi_arready;
  assign in_wait = (state == WR_REQ) || (state == WR_RESP) ||
                   (state == RD_REQ) || (state == RD_DATA);

  // AW and W retire independently; a channel whose valid is already low has completed.
  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      state         <= IDLE;
      cmd_ready     <= 1'b1;
      m_axi_awaddr  <= '0;
      m_axi_awvalid <= 1'b0;
      m_axi_wdata   <= '0;
      m_axi_wstrb   <= '0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
      m_axi_araddr  <= '0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_write     <= 1'b0;
      rsp_rdata     <= '0;
      rsp_resp      <= 2'b00;
      wd_cnt        <= '0;
      timeout       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            wd_cnt    <= '0;
            if (cmd_write) begin
              m_axi_awaddr  <= cmd_addr;
              m_axi_wdata   <= cmd_wdata;
              m_axi_wstrb   <= cmd_wstrb[STRB_W-1:0];
              m_axi_awvalid <= 1'b1;
              m_axi_wvalid  <= 1'b1;
              state         <= WR_REQ;
            end else begin
              m_axi_araddr  <= cmd_addr;
              m_axi_arvalid <= 1'b1;
              state         <= RD_REQ;
            end
          end
        end

        WR_REQ: begin
          if (aw_fire) m_axi_awvalid <= 1'b0;
          if (w_fire)  m_axi_wvalid  <= 1'b0;
          if ((!m_axi_awvalid || aw_fire) && (!m_axi_wvalid || w_fire)) begin
            m_axi_bready <= 1'b1;
            state        <= WR_RESP;
          end
        end

        WR_RESP: begin
          if (m_axi_bvalid && m_axi_bready) begin
            m_axi_bready <= 1'b0;
            rsp_resp     <= m_axi_bresp;
            rsp_rdata    <= '0;
            rsp_write    <= 1'b1;
            rsp_valid    <= 1'b1;
            state        <= RSP;
          end
        end

        RD_REQ: begin
          if (ar_fire) begin
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b1;
            state         <= RD_DATA;
          end
        end

        RD_DATA: begin
          if (m_axi_rvalid && m_axi_rready) begin
            m_axi_rready <= 1'b0;
            rsp_rdata    <= m_axi_rdata;
            rsp_resp     <= m_axi_rresp;
            rsp_write    <= 1'b0;
            rsp_valid    <= 1'b1;
            state        <= RSP;
          end
        end

        RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          m_axi_awvalid <= 1'b0;
          m_axi_wvalid  <= 1'b0;
          m_axi_bready  <= 1'b0;
          m_axi_arvalid <= 1'b0;
          m_axi_rready  <= 1'b0;
          rsp_valid     <= 1'b0;
          cmd_ready     <= 1'b1;
          state         <= IDLE;
        end
      endcase

      // Watchdog only flags the stall; the transaction keeps waiting for the responder.
      if ((TIMEOUT_CYCLES != 0) && in_wait && (wd_cnt != WD_LIMIT)) begin
        wd_cnt <= wd_cnt + 1'b1;
        if (wd_cnt == WD_LIMIT - 1'b1) timeout <= 1'b1;
      end
    end
  end

endmodule
